escalonador_quadro_jogo: RTL
============================

ESCALONADOR_QUADRO_JOGO -- requirements
Module: escalonador_quadro_jogo

Interface
REQ-001 SHALL have parameter TIMEOUT_CICLOS, default 1024, max cycles waited for any done.
REQ-002 SHALL have parameter PERIODO_GERACAO, default 8, frames between asteroid spawns (>=1).
REQ-003 SHALL have ports: clock in 1 system clock; reset in 1 asynchronous, active-high reset.
REQ-004 SHALL have inputs, all 1 bit: jogar (start), pausa, tick (frame-timer pulse), fim_movimento_tiros, fim_movimento_asteroides, fim_comparacao, fim_colisao_nave, colisao_nave, fim_renderizacao.
REQ-005 SHALL have 1-bit pulse outputs: reset_jogo, move_tiros, move_asteroides, gera_asteroide, compara_tiros_e_asteroides, verifica_colisao_nave, renderiza, tick_perdido.
REQ-006 SHALL have 1-bit level outputs fim_de_jogo and erro_timeout, and db_estado out 5 bits (state code).

Function
REQ-007 SHALL be a Moore FSM; codes: inicio 0, ocioso 1, espera_tick 2, move_tiros 3, aguarda_tiros 4, move_aste 5, aguarda_aste 6, gera_aste 7, compara 8, aguarda_compara 9, colisao 10, aguarda_colisao 11, renderiza 12, aguarda_render 13, fim_jogo 14, erro 15.
REQ-008 SHALL transition inicio->ocioso unconditionally, asserting reset_jogo for that one cycle.
REQ-009 SHALL leave ocioso for espera_tick when jogar=1.
REQ-010 SHALL leave espera_tick for move_tiros when (tick or tick_pendente) and pausa=0; pausa=1 holds state, pending tick retained.
REQ-011 SHALL assert each start pulse only in its issue state (3,5,7,8,10,12), exactly one cycle, then enter the matching aguarda state (gera_aste goes directly to compara).
REQ-012 SHALL ignore done inputs during issue states; in aguarda state, done=1 advances next cycle: tiros->move_aste, aste->gera_aste or compara, compara->colisao, colisao->fim_jogo if colisao_nave=1 else renderiza, render->espera_tick.
REQ-013 SHALL hold a watchdog counter (width clog2(TIMEOUT_CICLOS)+1) cleared on entry to every aguarda state, incremented each aguarda cycle; reaching TIMEOUT_CICLOS-1 without done -> erro; done on that same cycle wins.
REQ-014 SHALL keep frame counter 0..PERIODO_GERACAO-1, incremented in aguarda_aste on done; enter gera_aste when value was PERIODO_GERACAO-1 (wrap to 0), else compara.
REQ-015 SHALL set tick_pendente when tick=1 outside espera_tick, clear it on leaving espera_tick; tick while already pending pulses tick_perdido one cycle, no further queueing.
REQ-016 SHALL assert fim_de_jogo in fim_jogo; jogar=1 there -> inicio (new game).
REQ-017 SHALL assert erro_timeout in erro; erro is left only by reset.
REQ-018 SHALL map unused codes to inicio next cycle.

Reset
REQ-019 SHALL on reset: state inicio, watchdog 0, frame counter 0, tick_pendente 0, all pulse/level outputs 0, db_estado 0.
REQ-020 SHALL abort any in-flight phase on reset mid-frame without issuing further pulses.

Structure
REQ-021 SHALL place state codes and default parameter values in shared package pkg_astrogenius.
REQ-022 SHALL instantiate one sub-module contador_watchdog (clear, enable, terminal flag); all else inline.

Verification
REQ-023 jogar, tick, all done 2 cycles after each start -> pulse order move_tiros, move_asteroides, compara, verifica_colisao_nave, renderiza, return to state 2.
REQ-024 PERIODO_GERACAO=3, 6 full frames -> gera_asteroide in frames 3 and 6 only.
REQ-025 fim_comparacao withheld, TIMEOUT_CICLOS=16 -> erro at 16th aguarda cycle, erro_timeout=1 until reset.
REQ-026 colisao_nave=1 with fim_colisao_nave -> state 14, no renderiza, fim_de_jogo=1; jogar -> reset_jogo pulse.
REQ-027 two ticks during one frame -> one extra frame runs, tick_perdido pulses once; pausa=1 blocks frame start.

Source files
------------

// File: rtl/escalonador_quadro_jogo_pkg.sv
// Shared definitions for the game-frame scheduler: state codes and default timing values.
package pkg_astrogenius;

  localparam int TIMEOUT_CICLOS_PADRAO  = 1024;
  localparam int PERIODO_GERACAO_PADRAO = 8;

  typedef enum logic [4:0] {
    INICIO          = 5'd0,
    OCIOSO          = 5'd1,
    ESPERA_TICK     = 5'd2,
    MOVE_TIROS      = 5'd3,
    AGUARDA_TIROS   = 5'd4,
    MOVE_ASTE       = 5'd5,
    AGUARDA_ASTE    = 5'd6,
    GERA_ASTE       = 5'd7,
    COMPARA         = 5'd8,
    AGUARDA_COMPARA = 5'd9,
    COLISAO         = 5'd10,
    AGUARDA_COLISAO = 5'd11,
    RENDERIZA       = 5'd12,
    AGUARDA_RENDER  = 5'd13,
    FIM_JOGO        = 5'd14,
    ERRO            = 5'd15
  } estado_t;

  function automatic logic eh_aguarda(input estado_t e);
    return e inside {AGUARDA_TIROS, AGUARDA_ASTE, AGUARDA_COMPARA, AGUARDA_COLISAO, AGUARDA_RENDER};
  endfunction

endpackage

// File: rtl/escalonador_quadro_jogo_watchdog.sv
// Watchdog for the wait phases: counts cycles spent waiting and flags the last allowed one.
module contador_watchdog #(
  parameter int TIMEOUT_CICLOS = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = $clog2(TIMEOUT_CICLOS) + 1;
  localparam logic [W-1:0] LIMITE = W'(TIMEOUT_CICLOS - 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       contagem <= '0;
    else if (clear)  contagem <= '0;
    else if (enable) contagem <= contagem + 1'b1;
  end

  // Reads 0 on the first wait cycle, so LIMITE is reached on cycle TIMEOUT_CICLOS.
  assign terminal = enable && (contagem == LIMITE);

endmodule

// File: rtl/escalonador_quadro_jogo.sv
// Per-frame game scheduler: sequences shot/asteroid movement, spawning, collision checks
// and rendering once per frame tick, with a watchdog on every wait phase.
module escalonador_quadro_jogo
  import pkg_astrogenius::*;
#(
  parameter int TIMEOUT_CICLOS  = TIMEOUT_CICLOS_PADRAO,
  parameter int PERIODO_GERACAO = PERIODO_GERACAO_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       pausa,
  input  logic       tick,
  input  logic       fim_movimento_tiros,
  input  logic       fim_movimento_asteroides,
  input  logic       fim_comparacao,
  input  logic       fim_colisao_nave,
  input  logic       colisao_nave,
  input  logic       fim_renderizacao,
  output logic       reset_jogo,
  output logic       move_tiros,
  output logic       move_asteroides,
  output logic       gera_asteroide,
  output logic       compara_tiros_e_asteroides,
  output logic       verifica_colisao_nave,
  output logic       renderiza,
  output logic       tick_perdido,
  output logic       fim_de_jogo,
  output logic       erro_timeout,
  output logic [4:0] db_estado
);

  localparam int WQ = (PERIODO_GERACAO > 1) ? $clog2(PERIODO_GERACAO) : 1;
  localparam logic [WQ-1:0] ULTIMO_QUADRO = WQ'(PERIODO_GERACAO - 1);

  estado_t       estado, proximo;
  logic [WQ-1:0] quadro;
  logic          tick_pendente;
  logic          aguardando, sai_espera, ultimo, wd_terminal;

  assign aguardando = eh_aguarda(estado);
  assign sai_espera = (estado == ESPERA_TICK) && (tick || tick_pendente) && !pausa;
  assign ultimo     = (quadro == ULTIMO_QUADRO);

  contador_watchdog #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (!aguardando),
    .enable  (aguardando),
    .terminal(wd_terminal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIO;
    else       estado <= proximo;
  end

  always_comb begin
    proximo                    = estado;
    // reset_jogo is gated so it stays low while reset is held in inicio.
    reset_jogo                 = (estado == INICIO) && !reset;
    move_tiros                 = (estado == MOVE_TIROS);
    move_asteroides            = (estado == MOVE_ASTE);
    gera_asteroide             = (estado == GERA_ASTE);
    compara_tiros_e_asteroides = (estado == COMPARA);
    verifica_colisao_nave      = (estado == COLISAO);
    renderiza                  = (estado == RENDERIZA);
    fim_de_jogo                = (estado == FIM_JOGO);
    erro_timeout               = (estado == ERRO);
    db_estado                  = estado;
    case (estado)
      INICIO:          proximo = OCIOSO;
      OCIOSO:          if (jogar) proximo = ESPERA_TICK;
      ESPERA_TICK:     if (sai_espera) proximo = MOVE_TIROS;
      MOVE_TIROS:      proximo = AGUARDA_TIROS;
      AGUARDA_TIROS:   if (fim_movimento_tiros) proximo = MOVE_ASTE;
                       else if (wd_terminal) proximo = ERRO;
      MOVE_ASTE:       proximo = AGUARDA_ASTE;
      AGUARDA_ASTE:    if (fim_movimento_asteroides) proximo = ultimo ? GERA_ASTE : COMPARA;
                       else if (wd_terminal) proximo = ERRO;
      GERA_ASTE:       proximo = COMPARA;
      COMPARA:         proximo = AGUARDA_COMPARA;
      AGUARDA_COMPARA: if (fim_comparacao) proximo = COLISAO;
                       else if (wd_terminal) proximo = ERRO;
      COLISAO:         proximo = AGUARDA_COLISAO;
      AGUARDA_COLISAO: if (fim_colisao_nave) proximo = colisao_nave ? FIM_JOGO : RENDERIZA;
                       else if (wd_terminal) proximo = ERRO;
      RENDERIZA:       proximo = AGUARDA_RENDER;
      AGUARDA_RENDER:  if (fim_renderizacao) proximo = ESPERA_TICK;
                       else if (wd_terminal) proximo = ERRO;
      FIM_JOGO:        if (jogar) proximo = INICIO;
      ERRO:            proximo = ERRO;
      default:         proximo = INICIO;
    endcase
  end

  // Frame counter restarts with every new game; one pending tick at most, extras are reported lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quadro        <= '0;
      tick_pendente <= 1'b0;
      tick_perdido  <= 1'b0;
    end else begin
      tick_perdido <= tick && tick_pendente;
      if (sai_espera)  tick_pendente <= 1'b0;
      else if (tick)   tick_pendente <= 1'b1;
      if (estado == INICIO)
        quadro <= '0;
      else if ((estado == AGUARDA_ASTE) && fim_movimento_asteroides)
        quadro <= ultimo ? '0 : quadro + 1'b1;
    end
  end

endmodule
